// File: rtl/flash_pkg.sv
// Shared SPI flash definitions: opcodes, status-register bit positions,
// the 4-phase SPI bit encoding and the WIP poller state type.
package flash_pkg;

  localparam logic [7:0] OP_WR_EN = 8'h06;
  localparam logic [7:0] OP_PP    = 8'h12;
  localparam logic [7:0] OP_PPX4  = 8'h3E;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  // One SPI bit spans 4 clocks: mosi changes in phase 0, spi_clk is high
  // from PH_SCLK_RISE onwards, and miso is sampled in PH_LAST.
  localparam logic [1:0] PH_SCLK_RISE = 2'd2;
  localparam logic [1:0] PH_LAST      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_READ,
    ST_CHECK,
    ST_GAP,
    ST_FIN
  } poll_state_e;

endpackage

// File: rtl/flash_wip_poll_ctrl_spi_byte_shifter.sv
// Mode-0 single-bit SPI byte engine: 32 clocks per byte, MSB first both ways.
// A start on the last cycle of a byte chains the next byte with no idle gap.
module spi_byte_shifter
  import flash_pkg::*;
(
  input  logic       system_clk,
  input  logic       system_reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       done,
  output logic       spi_clk,
  output logic       mosi,
  output logic [7:0] rx_byte
);

  logic       active;
  logic [1:0] phase;
  logic [2:0] bit_idx;
  logic [7:0] tx_sr;
  logic [6:0] rx_sr;

  assign done    = active && (phase == PH_LAST) && (bit_idx == 3'd7);
  assign spi_clk = active && (phase >= PH_SCLK_RISE);
  assign mosi    = active && tx_sr[7];
  // Final bit is taken straight from miso so the byte is usable alongside done.
  assign rx_byte = {rx_sr, miso};

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      active  <= 1'b0;
      phase   <= 2'd0;
      bit_idx <= 3'd0;
      tx_sr   <= 8'h00;
    end else if (start && (!active || done)) begin
      active  <= 1'b1;
      phase   <= 2'd0;
      bit_idx <= 3'd0;
      tx_sr   <= tx_byte;
    end else if (active) begin
      phase <= phase + 2'd1;
      if (phase == PH_LAST) begin
        bit_idx <= bit_idx + 3'd1;
        tx_sr   <= {tx_sr[6:0], 1'b0};
        if (bit_idx == 3'd7) active <= 1'b0;
      end
    end
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n)                  rx_sr <= 7'h00;
    else if (active && phase == PH_LAST)  rx_sr <= {rx_sr[5:0], miso};
  end

endmodule

// File: rtl/flash_wip_poll_ctrl.sv
// Polls the flash status register with RDSR after a page program until WIP
// clears or MAX_POLLS polls have been made, then pulses done.
module flash_wip_poll_ctrl
  import flash_pkg::*;
#(
  parameter logic [7:0]  RDSR_INST = OP_RDSR,
  parameter logic [15:0] MAX_POLLS = 16'd50000,
  parameter int          CS_GAP    = 8          // must be >= 2
)(
  input  logic        system_clk,
  input  logic        system_reset_n,
  input  logic        start,
  output logic        cs_n,
  output logic        spi_clk,
  output logic        mosi,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  status,
  output logic [15:0] poll_cnt
);

  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  poll_state_e state, state_nxt;
  logic [7:0]  gap_cnt;
  logic        sh_start, sh_done;
  logic [7:0]  sh_tx, sh_rx;
  logic [16:0] poll_inc;
  logic        last_poll;

  assign poll_inc  = {1'b0, poll_cnt} + 17'd1;
  assign last_poll = (poll_inc == {1'b0, MAX_POLLS});

  spi_byte_shifter u_shifter (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .start          (sh_start),
    .tx_byte        (sh_tx),
    .miso           (miso),
    .done           (sh_done),
    .spi_clk        (spi_clk),
    .mosi           (mosi),
    .rx_byte        (sh_rx)
  );

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SEL;
      ST_SEL:   state_nxt = ST_CMD;
      ST_CMD:   if (sh_done) state_nxt = ST_READ;
      ST_READ:  if (sh_done) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!status[SR_WIP] || last_poll) state_nxt = ST_FIN;
        else                              state_nxt = ST_GAP;
      end
      ST_GAP:   if (gap_cnt == 8'd0) state_nxt = ST_SEL;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // cs_n is low from CMD through CHECK, i.e. asserted by SEL and released by CHECK.
  always_comb begin
    cs_n     = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    case (state)
      ST_IDLE:  busy = 1'b0;
      ST_SEL:   begin sh_start = 1'b1; sh_tx = RDSR_INST; end
      ST_CMD:   begin cs_n = 1'b0; sh_start = sh_done; end
      ST_READ:  cs_n = 1'b0;
      ST_CHECK: cs_n = 1'b0;
      ST_FIN:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      status   <= 8'h00;
      poll_cnt <= 16'd0;
      timeout  <= 1'b0;
      gap_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          poll_cnt <= 16'd0;
          timeout  <= 1'b0;
        end
        ST_READ: if (sh_done) status <= sh_rx;
        ST_CHECK: begin
          if (poll_cnt != MAX_POLLS) poll_cnt <= poll_inc[15:0];
          if (status[SR_WIP] && last_poll) timeout <= 1'b1;
          gap_cnt <= GAP_LOAD;
        end
        ST_GAP: gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_wip_poll_ctrl.sv
// Bench for flash_wip_poll_ctrl: a behavioural flash answers RDSR from a
// per-run list of status bytes; run results are checked against tables and a model.
module tb_flash_wip_poll_ctrl;

  localparam int MAXP = 5;
  localparam int GAP  = 8;

  logic        system_clk = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cs_n, spi_clk, mosi, busy, done, timeout;
  logic        miso = 1'b0;
  logic [7:0]  status;
  logic [15:0] poll_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  flash_wip_poll_ctrl #(
    .RDSR_INST (8'h05),
    .MAX_POLLS (16'(MAXP)),
    .CS_GAP    (GAP)
  ) dut (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .start          (start),
    .cs_n           (cs_n),
    .spi_clk        (spi_clk),
    .mosi           (mosi),
    .miso           (miso),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .status         (status),
    .poll_cnt       (poll_cnt)
  );

  always #5 system_clk = ~system_clk;

  // Flash response list for the current run: byte p answers poll p, last byte repeats.
  logic [5:0][7:0] cur_r = '0;
  int              cur_n = 1;
  int              epoch = 0;

  // Monitor / flash model state (owned by the monitor process only).
  int         mon_epoch = 0;
  int         poll_idx = 0, rise_cnt = 0, bad_cmd = 0, done_cnt = 0;
  int         min_gap = 9999, hi_run = 0, idle_bad = 0;
  logic [7:0] cmd_sh = 8'h00;
  logic [7:0] rbyte;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;

  function automatic logic [7:0] resp_byte(input int p);
    return (p < cur_n) ? cur_r[p] : cur_r[cur_n-1];
  endfunction

  always @(negedge system_clk) begin
    if (epoch != mon_epoch) begin
      mon_epoch = epoch; poll_idx = 0; rise_cnt = 0; bad_cmd = 0;
      done_cnt = 0; min_gap = 9999; hi_run = 0;
    end
    if (done) done_cnt++;
    if (!busy && (!cs_n || spi_clk || mosi)) idle_bad++;
    if (prev_cs && !cs_n) begin
      if (poll_idx > 0 && hi_run < min_gap) min_gap = hi_run;
      poll_idx++; rise_cnt = 0; cmd_sh = 8'h00;
    end
    if (cs_n) hi_run++; else hi_run = 0;
    if (!cs_n && !prev_sclk && spi_clk) begin
      if (rise_cnt < 8) cmd_sh = {cmd_sh[6:0], mosi};
      else if (mosi) bad_cmd++;
      rise_cnt++;
      if (rise_cnt == 8 && cmd_sh != 8'h05) bad_cmd++;
    end
    // Mode 0: the flash shifts its next status bit out on each falling spi_clk.
    if (!cs_n && prev_sclk && !spi_clk && rise_cnt >= 8 && rise_cnt < 16) begin
      rbyte = resp_byte(poll_idx - 1);
      miso = rbyte[7 - (rise_cnt - 8)];
    end else if (cs_n || rise_cnt < 8 || (rise_cnt >= 16 && !spi_clk)) begin
      miso = 1'($urandom);
    end
    prev_cs = cs_n;
    prev_sclk = spi_clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected outcome from the poll rules: stop at first WIP=0, else at MAXP with timeout.
  function automatic void model(input logic [5:0][7:0] r, input int n,
                                output int polls, output bit to, output logic [7:0] st);
    polls = 0; to = 1'b0; st = 8'h00;
    for (int i = 0; i < MAXP; i++) begin
      st = (i < n) ? r[i] : r[n-1];
      polls = i + 1;
      if (!st[0]) return;
    end
    to = 1'b1;
  endfunction

  // Edges counted from the one that samples start; done is visible after edge 67
  // (68 cycles including the start cycle), each extra poll adds GAP+66.
  function automatic int exp_latency(input int polls);
    return 67 + (polls - 1) * (GAP + 66);
  endfunction

  task automatic run_poll(input logic [5:0][7:0] r, input int n, input int extra_at,
                          output int lat);
    cur_r = r; cur_n = n; epoch++;
    @(negedge system_clk);
    start = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      start = (extra_at != 0 && lat == extra_at);
      @(negedge system_clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic do_run(input string tag, input logic [5:0][7:0] r, input int n,
                        input int extra_at, input int e_polls, input bit e_to,
                        input logic [7:0] e_st, input int e_lat);
    int lat;
    run_poll(r, n, extra_at, lat);
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " poll_cnt"}, poll_cnt, e_polls);
    chk({tag, " status"}, status, e_st);
    chk({tag, " timeout"}, timeout, e_to);
    // start coinciding with the done cycle must not relaunch
    start = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    chk({tag, " fin-start busy"}, busy, 0);
    chk({tag, " timeout held"}, timeout, e_to);
    @(negedge system_clk);
    chk({tag, " cs windows"}, poll_idx, e_polls);
    chk({tag, " bad cmd/mosi"}, bad_cmd, 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    if (e_polls > 1) chk({tag, " cs gap>=CS_GAP"}, (min_gap >= GAP), 1);
  endtask

  typedef struct {
    logic [5:0][7:0] r;
    int              n;
    int              polls;
    bit              to;
    logic [7:0]      st;
    int              lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int polls, lat;
    bit to;
    logic [7:0] st;
    logic [5:0][7:0] rr;
    int nn;

    vecs[0] = '{48'h0000_0000_0000, 1, 1, 1'b0, 8'h00, 67};
    vecs[1] = '{48'h0000_0203_0303, 4, 4, 1'b0, 8'h02, 289};
    vecs[2] = '{48'h0001_0101_0101, 5, 5, 1'b1, 8'h01, 363};
    vecs[3] = '{48'h0000_0101_0101, 5, 5, 1'b0, 8'h00, 363};
    vecs[4] = '{48'h0000_0000_FEFF, 2, 2, 1'b0, 8'hFE, 141};

    // Reset values while reset is held
    repeat (3) @(negedge system_clk);
    chk("rst cs_n", cs_n, 1);
    chk("rst spi_clk", spi_clk, 0);
    chk("rst mosi", mosi, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst timeout", timeout, 0);
    chk("rst status", status, 0);
    chk("rst poll_cnt", poll_cnt, 0);
    system_reset_n = 1'b1;
    repeat (2) @(negedge system_clk);

    foreach (vecs[i])
      do_run($sformatf("vec%0d", i), vecs[i].r, vecs[i].n, 0,
             vecs[i].polls, vecs[i].to, vecs[i].st, vecs[i].lat);

    // Second start 10 cycles into a run is ignored
    do_run("start-busy", 48'h0000_0000_0003, 2, 10, 2, 1'b0, 8'h00, exp_latency(2));

    // Reset during READ bit 4 (cycles 50..53 after the start edge)
    cur_r = 48'h0000_0000_0001; cur_n = 1; epoch++;
    @(negedge system_clk);
    start = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    for (int k = 1; k < 51; k++) @(negedge system_clk);
    chk("pre-reset cs_n low", cs_n, 0);
    system_reset_n = 1'b0;
    #1;
    chk("async rst cs_n", cs_n, 1);
    chk("async rst spi_clk", spi_clk, 0);
    chk("async rst busy", busy, 0);
    chk("async rst poll_cnt", poll_cnt, 0);
    repeat (3) @(negedge system_clk);
    system_reset_n = 1'b1;
    repeat (80) @(negedge system_clk);
    chk("reset no done", done_cnt, 0);
    do_run("post-reset", 48'h0000_0000_0000, 1, 0, 1, 1'b0, 8'h00, 67);

    // Randomized runs checked against the model
    for (int t = 0; t < 12; t++) begin
      nn = $urandom_range(1, 6);
      for (int b = 0; b < 6; b++) begin
        rr[b] = 8'($urandom);
        rr[b][0] = ($urandom_range(0, 9) < 7);
      end
      model(rr, nn, polls, to, st);
      do_run($sformatf("rand%0d", t), rr, nn, 0, polls, to, st, exp_latency(polls));
    end

    // Long idle with no start
    epoch++;
    repeat (1000) @(negedge system_clk);
    chk("idle done", done_cnt, 0);
    chk("idle outputs at rest", idle_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
